// File: rtl/ap_pkg.sv
// Shared types and constants for the ap_s_core associative processor.
// Word geometry, command/direction/state encodings and the row-wise reference ALU.
package ap_pkg;

  localparam int WORD_SIZE  = 8;
  localparam int CELL_QUANT = 512;
  localparam int ADDR_BITS  = $clog2(CELL_QUANT + 1);
  localparam int ROW_BITS   = $clog2(CELL_QUANT);
  localparam int BIT_BITS   = $clog2(WORD_SIZE);
  localparam int ITER_BITS  = $clog2(WORD_SIZE + 1);

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic [2:0] {
    CMD_OR   = 3'd0,
    CMD_XOR  = 3'd1,
    CMD_AND  = 3'd2,
    CMD_NOT  = 3'd3,
    CMD_ADD  = 3'd4,
    CMD_SUB  = 3'd5,
    CMD_MULT = 3'd6
  } cmd_e;

  localparam logic [1:0] COL_A    = 2'd0;
  localparam logic [1:0] COL_B    = 2'd1;
  localparam logic [1:0] COL_C    = 2'd2;
  localparam logic [1:0] COL_NONE = 2'd3;

  typedef enum logic {
    DIR_VERT = 1'b0,
    DIR_HORZ = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // The unused encoding 7 behaves as OR, so it is folded at latch time.
  function automatic cmd_e decode_cmd(input logic [2:0] raw);
    return (raw == 3'd7) ? CMD_OR : cmd_e'(raw);
  endfunction

  function automatic word_t alu_word(input cmd_e op, input word_t a, input word_t b);
    case (op)
      CMD_XOR:  return a ^ b;
      CMD_AND:  return a & b;
      CMD_NOT:  return ~a;
      CMD_ADD:  return a + b;
      CMD_SUB:  return a - b;
      CMD_MULT: return a * b;
      default:  return a | b;
    endcase
  endfunction

endpackage

// File: rtl/ap_s_core_if.sv
// Host-side bus of ap_s_core: operand load/readback, operation start and
// completion interrupt.
interface ap_s_core_if;
  import ap_pkg::*;

  logic [ADDR_BITS-1:0] addr_in;
  word_t                data_in;
  logic                 write_en;
  logic                 read_en;
  logic [1:0]           sel_col;
  logic                 sel_internal_col;
  logic                 op_direction;
  logic                 ap_mode;
  logic [2:0]           cmd;
  word_t                data_out;
  logic                 ap_state_irq;

  modport master (
    output addr_in, data_in, write_en, read_en, sel_col, sel_internal_col,
           op_direction, ap_mode, cmd,
    input  data_out, ap_state_irq
  );

  modport slave (
    input  addr_in, data_in, write_en, read_en, sel_col, sel_internal_col,
           op_direction, ap_mode, cmd,
    output data_out, ap_state_irq
  );

endinterface

// File: rtl/ap_column.sv
// One word column: two banks of CELL_QUANT words with a host word port,
// a whole-column bit-slice port and a single-row port on the active bank.
module ap_column
  import ap_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  act_bank,
  input  logic                  host_we,
  input  logic                  host_bank,
  input  logic [ROW_BITS-1:0]   host_addr,
  input  word_t                 host_wdata,
  output word_t                 host_rdata,
  input  logic [BIT_BITS-1:0]   slice_idx,
  input  logic                  slice_we,
  input  logic [CELL_QUANT-1:0] slice_wdata,
  output logic [CELL_QUANT-1:0] slice_rd,
  input  logic [ROW_BITS-1:0]   row_addr,
  input  logic                  row_we,
  input  word_t                 row_wdata,
  output word_t                 row_rd
);

  word_t mem_q [2][CELL_QUANT];
  word_t mem_d [2][CELL_QUANT];
  word_t cell_doutb_ctrl [CELL_QUANT];

  always_comb begin
    for (int i = 0; i < CELL_QUANT; i++) begin
      cell_doutb_ctrl[i] = mem_q[act_bank][i];
    end
  end

  always_comb begin
    for (int i = 0; i < CELL_QUANT; i++) begin
      slice_rd[i] = cell_doutb_ctrl[i][slice_idx];
    end
  end

  assign row_rd     = cell_doutb_ctrl[row_addr];
  assign host_rdata = mem_q[host_bank][host_addr];

  // The three write sources are mutually exclusive by FSM state.
  always_comb begin
    // NOTE: start from the current contents so every path assigns mem_d and no latch is inferred.
    mem_d = mem_q;
    if (host_we) begin
      mem_d[host_bank][host_addr] = host_wdata;
    end else if (slice_we) begin
      for (int i = 0; i < CELL_QUANT; i++) begin
        mem_d[act_bank][i][slice_idx] = slice_wdata[i];
      end
    end else if (row_we) begin
      mem_d[act_bank][row_addr] = row_wdata;
    end
  end

  // NOTE: the array is built from flops and must read as zero after reset, so it is reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < CELL_QUANT; i++) begin
          // NOTE: non-blocking assignment for all sequential state so every flop samples pre-edge values.
          mem_q[b][i] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/ap_s_core.sv
// Associative processor top: host port, IDLE/RUN/DONE sequencer, bit-serial
// slice engine with per-row carry vector, and row-serial word ALU.
module ap_s_core
  import ap_pkg::*;
(
  input logic        CLK100MHZ,
  input logic        rst_n,
  ap_s_core_if.slave bus
);

  state_e                state_q, state_d;
  cmd_e                  cmd_q, cmd_d;
  dir_e                  dir_q, dir_d;
  logic                  bank_q, bank_d;
  logic [BIT_BITS-1:0]   bit_q, bit_d;
  logic [ITER_BITS-1:0]  iter_q, iter_d;
  logic [ROW_BITS-1:0]   row_q, row_d;
  logic [CELL_QUANT-1:0] carry_q, carry_d;
  logic                  irq_q, irq_d;
  word_t                 dout_q, dout_d;

  logic [ROW_BITS-1:0]   host_addr;
  logic                  addr_msb_unused;
  logic                  we_a, we_b, we_c;
  word_t                 host_rd_a, host_rd_b, host_rd_c;
  logic [BIT_BITS-1:0]   mult_k, a_idx, b_idx;
  logic [CELL_QUANT-1:0] a_slice, b_slice, c_slice;
  logic [CELL_QUANT-1:0] mult_addend, slice_sum, carry_next;
  logic                  slice_we, row_we;
  word_t                 a_row, b_row, row_result, c_row_unused;

  // Rows wrap modulo CELL_QUANT; the extra address bit carries no meaning.
  assign host_addr       = bus.addr_in[ROW_BITS-1:0];
  assign addr_msb_unused = bus.addr_in[ADDR_BITS-1];

  assign bus.data_out     = dout_q;
  assign bus.ap_state_irq = irq_q;

  ap_column cam_a (
    .clk(CLK100MHZ), .rst_n, .act_bank(bank_q),
    .host_we(we_a), .host_bank(bus.sel_internal_col), .host_addr,
    .host_wdata(bus.data_in), .host_rdata(host_rd_a),
    .slice_idx(a_idx), .slice_we(1'b0), .slice_wdata('0), .slice_rd(a_slice),
    .row_addr(row_q), .row_we(1'b0), .row_wdata('0), .row_rd(a_row)
  );

  ap_column cam_b (
    .clk(CLK100MHZ), .rst_n, .act_bank(bank_q),
    .host_we(we_b), .host_bank(bus.sel_internal_col), .host_addr,
    .host_wdata(bus.data_in), .host_rdata(host_rd_b),
    .slice_idx(b_idx), .slice_we(1'b0), .slice_wdata('0), .slice_rd(b_slice),
    .row_addr(row_q), .row_we(1'b0), .row_wdata('0), .row_rd(b_row)
  );

  ap_column cam_c (
    .clk(CLK100MHZ), .rst_n, .act_bank(bank_q),
    .host_we(we_c), .host_bank(bus.sel_internal_col), .host_addr,
    .host_wdata(bus.data_in), .host_rdata(host_rd_c),
    .slice_idx(bit_q), .slice_we, .slice_wdata(slice_sum), .slice_rd(c_slice),
    .row_addr(row_q), .row_we, .row_wdata(row_result), .row_rd(c_row_unused)
  );

  // MULT iteration k (iter_q = k+1) adds A<<k, so bit j of the addend is A bit j-k.
  always_comb begin
    mult_k = BIT_BITS'(iter_q - 1'b1);
    a_idx  = bit_q;
    b_idx  = bit_q;
    if (cmd_q == CMD_MULT) begin
      a_idx = bit_q - mult_k;
      b_idx = mult_k;
    end
  end

  always_comb begin
    mult_addend = (bit_q >= mult_k) ? (a_slice & b_slice) : '0;
    slice_sum   = a_slice | b_slice;
    carry_next  = carry_q;
    case (cmd_q)
      CMD_XOR: slice_sum = a_slice ^ b_slice;
      CMD_AND: slice_sum = a_slice & b_slice;
      CMD_NOT: slice_sum = ~a_slice;
      CMD_ADD: begin
        slice_sum  = a_slice ^ b_slice ^ carry_q;
        carry_next = (a_slice & b_slice) | (carry_q & (a_slice ^ b_slice));
      end
      CMD_SUB: begin
        slice_sum  = a_slice ^ b_slice ^ carry_q;
        carry_next = (~a_slice & b_slice) | (~(a_slice ^ b_slice) & carry_q);
      end
      CMD_MULT: begin
        if (iter_q == '0) begin
          slice_sum = '0;
        end else begin
          slice_sum  = c_slice ^ mult_addend ^ carry_q;
          carry_next = (c_slice & mult_addend) | (carry_q & (c_slice ^ mult_addend));
        end
      end
      default: ;
    endcase
  end

  assign row_result = alu_word(cmd_q, a_row, b_row);

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    dir_d    = dir_q;
    bank_d   = bank_q;
    bit_d    = bit_q;
    iter_d   = iter_q;
    row_d    = row_q;
    carry_d  = carry_q;
    irq_d    = irq_q;
    dout_d   = dout_q;
    we_a     = 1'b0;
    we_b     = 1'b0;
    we_c     = 1'b0;
    slice_we = 1'b0;
    row_we   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.ap_mode) begin
          state_d = ST_RUN;
          cmd_d   = decode_cmd(bus.cmd);
          dir_d   = dir_e'(bus.op_direction);
          bank_d  = bus.sel_internal_col;
          bit_d   = '0;
          iter_d  = '0;
          row_d   = '0;
          carry_d = '0;
        end else if (bus.write_en) begin
          we_a = (bus.sel_col == COL_A);
          we_b = (bus.sel_col == COL_B);
          we_c = (bus.sel_col == COL_C);
        end else if (bus.read_en) begin
          case (bus.sel_col)
            COL_A:   dout_d = host_rd_a;
            COL_B:   dout_d = host_rd_b;
            COL_C:   dout_d = host_rd_c;
            default: dout_d = '0;
          endcase
        end
      end
      ST_RUN: begin
        if (!bus.ap_mode) begin
          state_d = ST_IDLE;
        end else if (dir_q == DIR_HORZ) begin
          row_we = 1'b1;
          row_d  = row_q + 1'b1;
          if (row_q == ROW_BITS'(CELL_QUANT - 1)) begin
            state_d = ST_DONE;
            irq_d   = 1'b1;
          end
        end else begin
          slice_we = 1'b1;
          carry_d  = carry_next;
          bit_d    = bit_q + 1'b1;
          // Carries never cross a word boundary or a MULT iteration.
          if (bit_q == BIT_BITS'(WORD_SIZE - 1)) begin
            carry_d = '0;
            if (cmd_q != CMD_MULT || iter_q == ITER_BITS'(WORD_SIZE)) begin
              state_d = ST_DONE;
              irq_d   = 1'b1;
            end else begin
              iter_d = iter_q + 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        if (!bus.ap_mode) begin
          state_d = ST_IDLE;
          irq_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_OR;
      dir_q   <= DIR_VERT;
      bank_q  <= 1'b0;
      bit_q   <= '0;
      iter_q  <= '0;
      row_q   <= '0;
      carry_q <= '0;
      irq_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      dir_q   <= dir_d;
      bank_q  <= bank_d;
      bit_q   <= bit_d;
      iter_q  <= iter_d;
      row_q   <= row_d;
      carry_q <= carry_d;
      irq_q   <= irq_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_ap_s_core.sv
// Randomized bench for ap_s_core: a word-level array model of the three
// columns predicts every readback, run length and interrupt edge.
module tb_ap_s_core;
  import ap_pkg::*;

  logic CLK100MHZ = 1'b0;
  logic rst_n;

  ap_s_core_if bus ();

  ap_s_core dut (
    .CLK100MHZ(CLK100MHZ),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int total = 0;
  int bad   = 0;
  int mdl [3][2][CELL_QUANT];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_op(input int op, input int a, input int b);
    case (op)
      1:       return a ^ b;
      2:       return a & b;
      3:       return (~a) & 255;
      4:       return (a + b) % 256;
      5:       return (a - b + 256) % 256;
      6:       return (a * b) % 256;
      default: return a | b;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic host_write(input int col, input int bank, input int addr, input int data);
    bus.sel_col          = 2'(col);
    bus.sel_internal_col = 1'(bank);
    bus.addr_in          = ADDR_BITS'(addr);
    bus.data_in          = 8'(data);
    bus.write_en         = 1'b1;
    tick();
    bus.write_en = 1'b0;
    if (col < 3) mdl[col][bank][addr % CELL_QUANT] = data & 255;
  endtask

  task automatic host_read(input int col, input int bank, input int addr, output logic [7:0] data);
    bus.sel_col          = 2'(col);
    bus.sel_internal_col = 1'(bank);
    bus.addr_in          = ADDR_BITS'(addr);
    bus.read_en          = 1'b1;
    tick();
    bus.read_en = 1'b0;
    data = bus.data_out;
  endtask

  task automatic verify_col(input int col, input int bank, input string tag);
    logic [7:0] got;
    for (int r = 0; r < CELL_QUANT; r++) begin
      host_read(col, bank, r, got);
      check($sformatf("%s_c%0d_b%0d_r%0d", tag, col, bank, r), got, mdl[col][bank][r]);
    end
  endtask

  task automatic sweep(input string tag);
    for (int c = 0; c < 3; c++) begin
      for (int b = 0; b < 2; b++) verify_col(c, b, tag);
    end
  endtask

  task automatic load_ab(input int bank, input bit nibble);
    for (int r = 0; r < CELL_QUANT; r++) begin
      host_write(COL_A, bank, r, nibble ? $urandom_range(15) : $urandom_range(255));
      host_write(COL_B, bank, r, nibble ? $urandom_range(15) : $urandom_range(255));
    end
  endtask

  task automatic run_op(input int op, input int dir, input int bank, input int exp_cyc,
                        input string tag);
    int cyc = 0;
    bus.cmd              = 3'(op);
    bus.op_direction     = 1'(dir);
    bus.sel_internal_col = 1'(bank);
    bus.ap_mode          = 1'b1;
    tick();
    while (bus.ap_state_irq !== 1'b1 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check({tag, "_cycles"}, cyc, exp_cyc);
    // A host write while the operation is finished but ap_mode is high must be ignored.
    bus.sel_col  = COL_A;
    bus.addr_in  = '0;
    bus.data_in  = 8'h5a;
    bus.write_en = 1'b1;
    tick();
    bus.write_en = 1'b0;
    tick();
    tick();
    check({tag, "_irq_hold"}, bus.ap_state_irq, 1);
    bus.ap_mode = 1'b0;
    check({tag, "_irq_pre_fall"}, bus.ap_state_irq, 1);
    tick();
    check({tag, "_irq_fall"}, bus.ap_state_irq, 0);
    for (int r = 0; r < CELL_QUANT; r++) begin
      mdl[COL_C][bank][r] = ref_op(op, mdl[COL_A][bank][r], mdl[COL_B][bank][r]);
    end
  endtask

  task automatic set_edge_cases(input int bank);
    host_write(COL_A, bank, 0, 15);
    host_write(COL_B, bank, 0, 15);
    host_write(COL_A, bank, 1, 255);
    host_write(COL_B, bank, 1, 2);
  endtask

  initial begin
    logic [7:0] got;
    int ops [7] = '{0, 1, 2, 3, 4, 5, 7};

    bus.addr_in          = '0;
    bus.data_in          = '0;
    bus.write_en         = 1'b0;
    bus.read_en          = 1'b0;
    bus.sel_col          = '0;
    bus.sel_internal_col = 1'b0;
    bus.op_direction     = 1'b0;
    bus.ap_mode          = 1'b0;
    bus.cmd              = '0;
    rst_n                = 1'b0;
    for (int c = 0; c < 3; c++)
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < CELL_QUANT; r++) mdl[c][b][r] = 0;

    repeat (3) @(posedge CLK100MHZ);
    #1;
    rst_n = 1'b1;
    tick();
    check("rst_dout", bus.data_out, 0);
    check("rst_irq", bus.ap_state_irq, 0);
    sweep("rst");

    // Host port: write/readback, hold, unselected column, address wrap.
    host_write(COL_A, 0, 5, 171);
    host_write(COL_B, 0, 5, 167);
    host_read(COL_A, 0, 5, got);
    check("rd_a5", got, 171);
    host_read(COL_B, 0, 5, got);
    check("rd_b5", got, 167);
    bus.addr_in = 10'd9;
    bus.sel_col = COL_C;
    tick();
    check("dout_hold", bus.data_out, 167);
    host_write(3, 0, 5, 99);
    host_read(3, 0, 5, got);
    check("rd_none", got, 0);
    host_write(COL_A, 1, CELL_QUANT + 7, 77);
    host_read(COL_A, 1, 7, got);
    check("addr_wrap_wr", got, 77);
    host_read(COL_A, 1, CELL_QUANT + 7, got);
    check("addr_wrap_rd", got, 77);
    for (int c = 0; c < 3; c++) begin
      for (int b = 0; b < 2; b++) begin
        host_read(c, b, 5, got);
        check($sformatf("none_wr_c%0d_b%0d", c, b), got, mdl[c][b][5]);
      end
    end

    // Horizontal ADD with a known pattern.
    for (int r = 0; r < CELL_QUANT; r++) begin
      host_write(COL_A, 0, r, 1);
      host_write(COL_B, 0, r, (r >= CELL_QUANT - 4) ? 0 : r % 3);
    end
    run_op(4, 1, 0, CELL_QUANT, "h_add");
    verify_col(COL_C, 0, "h_add");

    // Vertical logic and arithmetic ops on random data.
    foreach (ops[i]) begin
      load_ab(i % 2, 1'b0);
      if (ops[i] == 4) begin
        host_write(COL_A, i % 2, 0, 200);
        host_write(COL_B, i % 2, 0, 100);
      end
      if (ops[i] == 5) begin
        host_write(COL_A, i % 2, 1, 3);
        host_write(COL_B, i % 2, 1, 5);
      end
      run_op(ops[i], 0, i % 2, WORD_SIZE, $sformatf("v_op%0d", ops[i]));
      verify_col(COL_C, i % 2, $sformatf("v_op%0d", ops[i]));
      if (ops[i] == 4) begin
        host_read(COL_C, i % 2, 0, got);
        check("add_wrap", got, 44);
      end
      if (ops[i] == 5) begin
        host_read(COL_C, i % 2, 1, got);
        check("sub_wrap", got, 254);
      end
    end

    // MULT in both directions with 4-bit operands plus edge rows.
    load_ab(1, 1'b1);
    set_edge_cases(1);
    run_op(6, 0, 1, WORD_SIZE * (WORD_SIZE + 1), "v_mul");
    verify_col(COL_C, 1, "v_mul");
    host_read(COL_C, 1, 0, got);
    check("v_mul_15x15", got, 225);
    host_read(COL_C, 1, 1, got);
    check("v_mul_255x2", got, 254);

    load_ab(0, 1'b1);
    set_edge_cases(0);
    run_op(6, 1, 0, CELL_QUANT, "h_mul");
    verify_col(COL_C, 0, "h_mul");
    host_read(COL_C, 0, 0, got);
    check("h_mul_15x15", got, 225);
    host_read(COL_C, 0, 1, got);
    check("h_mul_255x2", got, 254);

    // Abort a horizontal ADD after 100 rows.
    load_ab(1, 1'b0);
    bus.cmd              = 3'd4;
    bus.op_direction     = 1'b1;
    bus.sel_internal_col = 1'b1;
    bus.ap_mode          = 1'b1;
    tick();
    repeat (100) tick();
    check("abort_irq_run", bus.ap_state_irq, 0);
    bus.ap_mode = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("abort_irq_%0d", k), bus.ap_state_irq, 0);
      tick();
    end
    for (int r = 0; r < 100; r++) begin
      mdl[COL_C][1][r] = ref_op(4, mdl[COL_A][1][r], mdl[COL_B][1][r]);
    end
    verify_col(COL_C, 1, "abort");
    host_write(COL_A, 1, 3, 42);
    host_read(COL_A, 1, 3, got);
    check("abort_host_wr", got, 42);

    sweep("mid");

    // Asynchronous reset in the middle of a vertical MULT.
    host_read(COL_A, 1, 3, got);
    check("pre_rst_rd", got, 42);
    bus.cmd              = 3'd6;
    bus.op_direction     = 1'b0;
    bus.sel_internal_col = 1'b0;
    bus.ap_mode          = 1'b1;
    tick();
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dout", bus.data_out, 0);
    check("arst_irq", bus.ap_state_irq, 0);
    bus.ap_mode = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_irq_after", bus.ap_state_irq, 0);
    for (int c = 0; c < 3; c++)
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < CELL_QUANT; r++) mdl[c][b][r] = 0;
    sweep("arst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
